bitrev_reorder_buf: RTL

//  Output reorder stage placed directly after the last SdfUnit of the radix-2^2 SDF FFT chain.
//  - The pipeline emits each N-point frame in bit-reversed index order.
//  - This block writes each frame into one bank of a ping-pong buffer at the bit-reversed address.
//  - It reads the other bank in natural order, so X[0..N-1] leaves as a contiguous burst.

---
 rtl/bitrev_reorder_buf.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bitrev_reorder_buf.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order and leave in natural order.
// Optional start-of-frame output odata_sof is enabled by defining BITREV_SOF_EN.
module bitrev_reorder_buf #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
`ifdef BITREV_SOF_EN
  output logic             odata_sof,
`endif
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i
);

  localparam int            NN   = $clog2(N);
  localparam logic [NN-1:0] LAST = NN'(N - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  logic [NN-1:0]      wr_count_reg, wr_count_next;
  logic [NN-1:0]      wr_addr;
  logic               wr_bank_reg, wr_bank_next;
  logic               frame_done;

  state_t             state_reg, state_next;
  logic [NN-1:0]      rd_count_reg, rd_count_next;
  logic               rd_bank_reg, rd_bank_next;
  logic               rd_en;
  logic [NN:0]        rd_addr;

  logic [2*WIDTH-1:0] mem [0:2*N-1];

  assign frame_done = idata_en && (wr_count_reg == LAST);

  generate
    for (genvar gi = 0; gi < NN; gi++) begin : g_bitrev
      assign wr_addr[gi] = wr_count_reg[NN-1-gi];
    end
  endgenerate

  // Counter wraps N-1 -> 0 on its own; dropping idata_en mid-frame discards the partial frame.
  always_comb begin
    wr_count_next = idata_en ? wr_count_reg + NN'(1) : '0;
    wr_bank_next  = wr_bank_reg ^ frame_done;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_count_reg <= '0;
      wr_bank_reg  <= 1'b0;
    end else begin
      wr_count_reg <= wr_count_next;
      wr_bank_reg  <= wr_bank_next;
    end
  end

  always_ff @(posedge clock) begin
    if (idata_en) begin
      mem[{wr_bank_reg, wr_addr}] <= {idata_r, idata_i};
    end
  end

  // A completing frame always (re)starts the drain, which also covers the gapless hand-over.
  always_comb begin
    state_next    = state_reg;
    rd_count_next = rd_count_reg;
    rd_bank_next  = rd_bank_reg;
    if (frame_done) begin
      state_next    = DRAIN;
      rd_bank_next  = wr_bank_reg;
      rd_count_next = '0;
    end else if (state_reg == DRAIN) begin
      rd_count_next = rd_count_reg + NN'(1);
      if (rd_count_reg == LAST) begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      rd_count_reg <= '0;
      rd_bank_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_count_reg <= rd_count_next;
      rd_bank_reg  <= rd_bank_next;
    end
  end

  assign rd_en   = (state_reg == DRAIN);
  assign rd_addr = {rd_bank_reg, rd_count_reg};

  // The memory read register doubles as the output register; data holds while idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      odata_en <= 1'b0;
      odata_r  <= '0;
      odata_i  <= '0;
    end else begin
      odata_en <= rd_en;
      if (rd_en) begin
        {odata_r, odata_i} <= mem[rd_addr];
      end
    end
  end

`ifdef BITREV_SOF_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      odata_sof <= 1'b0;
    end else begin
      odata_sof <= rd_en && (rd_count_reg == '0);
    end
  end
`endif

endmodule
